// File: rtl/led_trail_pkg.sv
// ============================================================================
// Module   : led_trail_pkg
// Purpose  : Shared defaults and the brightness level type for led_trail_pwm.
// Revision : 1.0
// ============================================================================
`default_nettype none

package led_trail_pkg;

    localparam int unsigned   DEF_N_LEDS      = 8;
    localparam int unsigned   DEF_PWM_BITS    = 8;
    localparam logic [31:0]   DEF_DECAY_TICKS = 32'd500_000;
    localparam logic [7:0]    DEF_DECAY_STEP  = 8'd16;

    typedef logic [DEF_PWM_BITS-1:0] level_t;

endpackage : led_trail_pkg

`default_nettype wire

// File: rtl/led_trail_channel.sv
// ============================================================================
// Module   : led_trail_channel
// Purpose  : One LED channel: level register with saturating fade, optional
//            gamma stage (LED_TRAIL_GAMMA_EN) and registered PWM compare.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_trail_channel
    import led_trail_pkg::*;
#(
    parameter int unsigned           PWM_BITS   = DEF_PWM_BITS,
    parameter logic [PWM_BITS-1:0]   DECAY_STEP = PWM_BITS'(DEF_DECAY_STEP)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                decay_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                en,
    output logic                led,
    output logic                nonzero
);

    localparam logic [PWM_BITS-1:0] c_MAX = '1;

    logic [PWM_BITS-1:0] r_level;
    logic                r_led;
    logic                w_cmp_max;
    logic [PWM_BITS-1:0] w_cmp_lvl;

    // A fresh request wins over a decay step landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (load) begin
            r_level <= c_MAX;
        end else if (decay_tick) begin
            r_level <= (r_level > DECAY_STEP) ? (r_level - DECAY_STEP) : '0;
        end
    end

`ifdef LED_TRAIL_GAMMA_EN
    logic [2*PWM_BITS-1:0] w_lvl_ext;
    logic [2*PWM_BITS-1:0] w_sq;
    logic [PWM_BITS-1:0]   r_g;
    logic                  r_is_max;

    assign w_lvl_ext = {{PWM_BITS{1'b0}}, r_level};
    assign w_sq      = w_lvl_ext * w_lvl_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g      <= '0;
            r_is_max <= 1'b0;
        end else begin
            r_g      <= PWM_BITS'(w_sq >> PWM_BITS);
            r_is_max <= (r_level == c_MAX);
        end
    end

    assign w_cmp_max = r_is_max;
    assign w_cmp_lvl = r_g;
`else
    assign w_cmp_max = (r_level == c_MAX);
    assign w_cmp_lvl = r_level;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= 1'b0;
        end else begin
            r_led <= en && (w_cmp_max || (pwm_cnt < w_cmp_lvl));
        end
    end

    assign led     = r_led;
    assign nonzero = |r_level;

endmodule : led_trail_channel

`default_nettype wire

// File: rtl/led_trail_pwm.sv
// ============================================================================
// Module   : led_trail_pwm
// Purpose  : Scanner afterglow PWM driver: decay prescaler, PWM counter and
//            N_LEDS fading channels. Optional gamma via LED_TRAIL_GAMMA_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module led_trail_pwm
    import led_trail_pkg::*;
#(
    parameter int unsigned           N_LEDS      = DEF_N_LEDS,
    parameter int unsigned           PWM_BITS    = DEF_PWM_BITS,
    parameter logic [31:0]           DECAY_TICKS = DEF_DECAY_TICKS,
    parameter logic [PWM_BITS-1:0]   DECAY_STEP  = PWM_BITS'(DEF_DECAY_STEP)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [N_LEDS-1:0] pattern,
    output logic [N_LEDS-1:0] led_out,
    output logic              active
);

    logic [31:0]         r_presc;
    logic                r_decay_tick;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_active;
    logic [N_LEDS-1:0]   w_nonzero;
    logic [N_LEDS-1:0]   w_led;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc      <= '0;
            r_decay_tick <= 1'b0;
        end else if (r_presc == (DECAY_TICKS - 32'd1)) begin
            r_presc      <= '0;
            r_decay_tick <= 1'b1;
        end else begin
            r_presc      <= r_presc + 32'd1;
            r_decay_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_active  <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_active  <= |w_nonzero;
        end
    end

    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_chan
        led_trail_channel #(
            .PWM_BITS   (PWM_BITS),
            .DECAY_STEP (DECAY_STEP)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (pattern[gi]),
            .decay_tick (r_decay_tick),
            .pwm_cnt    (r_pwm_cnt),
            .en         (en),
            .led        (w_led[gi]),
            .nonzero    (w_nonzero[gi])
        );
    end

    assign led_out = w_led;
    assign active  = r_active;

endmodule : led_trail_pwm

`default_nettype wire

// File: tb/tb_led_trail_pwm.sv
// ============================================================================
// Module   : tb_led_trail_pwm
// Purpose  : Randomised scoreboard bench for led_trail_pwm (PWM_BITS=4,
//            DECAY_TICKS=4, DECAY_STEP=4); follows LED_TRAIL_GAMMA_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_led_trail_pwm;

    localparam int N    = 8;
    localparam int D    = 4;
    localparam int STEP = 4;
    localparam int MAXV = 15;
    localparam int PER  = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [N-1:0] led_out;
    logic         active;

    typedef struct packed {
        logic [N-1:0] led;
        logic         act;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference state: brightness per LED, gamma pipeline, edges since reset.
    int   lvl[N];
    int   gv[N];
    bit   gmax[N];
    int   edges = 0;
    bit   last_act = 1'b0;

    led_trail_pwm #(
        .N_LEDS      (N),
        .PWM_BITS    (4),
        .DECAY_TICKS (32'd4),
        .DECAY_STEP  (4'd4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pattern (pattern),
        .led_out (led_out),
        .active  (active)
    );

    always #5 clk = ~clk;

    // Advance the model across the coming clock edge and queue what the DUT
    // must show right after it.
    task automatic model_edge(input bit r, input logic [N-1:0] p, input bit e_in);
        exp_t x;
        int   pwm;
        bit   tick;
        x = '0;
        if (!r) begin
            for (int i = 0; i < N; i++) begin
                lvl[i] = 0; gv[i] = 0; gmax[i] = 1'b0;
            end
            edges = 0;
        end else begin
            pwm  = edges % PER;
            tick = (edges > 0) && (edges % D == 0);
            for (int i = 0; i < N; i++) begin
                if (lvl[i] != 0) x.act = 1'b1;
`ifdef LED_TRAIL_GAMMA_EN
                x.led[i] = e_in && (gmax[i] || (pwm < gv[i]));
                gv[i]    = (lvl[i] * lvl[i]) / PER;
                gmax[i]  = (lvl[i] == MAXV);
`else
                x.led[i] = e_in && ((lvl[i] == MAXV) || (pwm < lvl[i]));
`endif
                if (p[i])      lvl[i] = MAXV;
                else if (tick) lvl[i] = (lvl[i] > STEP) ? lvl[i] - STEP : 0;
            end
            edges++;
        end
        last_act = x.act;
        q.push_back(x);
    endtask

    task automatic drive(input logic [N-1:0] p, input bit e_in);
        @(negedge clk);
        rst_n   = 1'b1;
        pattern = p;
        en      = e_in;
        model_edge(1'b1, p, e_in);
    endtask

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tests++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act_v, exp_v, $time);
        end
    endtask

    // Monitor: every cycle is an output beat; compare just after the edge.
    initial begin
        exp_t mx;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                mx = q.pop_front();
                n_tests++;
                if ({led_out, active} !== mx) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t led_out=%h active=%b expected led_out=%h active=%b",
                             $time, led_out, active, mx.led, mx.act);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] p;
        bit           e_r;
        int           guard;

        for (int i = 0; i < N; i++) begin
            lvl[i] = 0; gv[i] = 0; gmax[i] = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            model_edge(1'b0, '0, 1'b0);
        end

        // Single pulse on LED 0, then let it fade out completely.
        drive(8'h01, 1'b1);
        repeat (90) drive(8'h00, 1'b1);

        // Request landing in the same cycle as a decay tick.
        guard = 0;
        while (!((edges > 0) && (edges % D == 0)) && guard < 10) begin
            drive(8'h00, 1'b1);
            guard++;
        end
        drive(8'h04, 1'b1);
        repeat (40) drive(8'h00, 1'b1);

        // Enable dropped mid-fade, restored one decay period later.
        drive(8'h80, 1'b1);
        repeat (6) drive(8'h00, 1'b1);
        repeat (D + 1) drive(8'h00, 1'b0);
        repeat (40) drive(8'h00, 1'b1);

        // Randomised traffic: sparse requests, occasional multi-bit, mostly enabled.
        for (int c = 0; c < 2000; c++) begin
            case ($urandom_range(0, 15))
                0, 1:    p = N'(1) << $urandom_range(0, N - 1);
                2:       p = N'($urandom);
                default: p = '0;
            endcase
            e_r = ($urandom_range(0, 9) != 0);
            drive(p, e_r);
        end

        // Asynchronous reset while the trail is still glowing.
        drive(8'hFF, 1'b1);
        repeat (5) drive(8'h00, 1'b1);
        @(negedge clk);
        check("pre_reset_active", {31'd0, active}, {31'd0, last_act});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_led", {24'd0, led_out}, 32'd0);
        check("async_reset_active", {31'd0, active}, 32'd0);
        model_edge(1'b0, '0, 1'b1);
        @(negedge clk);
        model_edge(1'b0, '0, 1'b1);
        repeat (30) drive(8'h00, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_led_trail_pwm

`default_nettype wire
